led_matrix_scan_driver: RTL
===========================

// Module: led_matrix_scan_driver
// PURPOSE
//  Downstream display stage for the falling-object game. The game logic writes 8x8 frame rows
//  (red/green/blue planes, active-low pixel = lit) into a back buffer, then requests a commit.
//  This block multiplexes the front buffer onto the shared 8x8 RGB matrix one row at a time.
//  At the row-7 -> row-0 boundary it swaps back and front buffers, so a frame never tears.
// PARAMETERS
//  ROW_DIV    10002  CLK cycles per displayed row (scan rate = CLK/(8*ROW_DIV)); must be > BLANK_CYC+8
//  BLANK_CYC  16     cycles at the start of each row with all colour outputs forced to 8'hFF (anti-ghost)
// PORTS
//  CLK            in   1  system clock
//  clear          in   1  synchronous reset, active-high
//  wr_valid       in   1  row write request into back buffer
//  wr_ready       out  1  back buffer accepts writes; a write occurs when wr_valid && wr_ready
//  wr_row         in   3  back-buffer row index for the write
//  wr_red         in   8  red plane for the row, active-low
//  wr_green       in   8  green plane for the row, active-low
//  wr_blue        in   8  blue plane for the row, active-low
//  frame_commit   in   1  1-cycle request: show back buffer from next frame boundary
//  commit_pending out  1  commit accepted, swap not yet done
//  frame_start    out  1  1-cycle pulse when row 0 becomes active
//  COMM           out  3  active row select to matrix
//  EN             out  1  matrix enable
//  red,green,blue out  8  column drive for active row, active-low
// BEHAVIOUR
//  - Reset (clear=1 at posedge): both banks = 8'hFF per row; front bank = 0; row counter and
//    prescaler = 0; COMM=0; EN=0; red/green/blue=8'hFF; wr_ready=0; commit_pending=0;
//    frame_start=0. First cycle after clear: EN=1, wr_ready=1. A clear mid-frame or mid-commit
//    discards everything.
//  - Prescaler counts 0..ROW_DIV-1. On wrap, row advances (7 wraps to 0) and COMM updates on the
//    same edge. frame_start=1 for exactly the cycle on which COMM becomes 0.
//  - Colour outputs are registered. For prescaler < BLANK_CYC they are 8'hFF. Otherwise they
//    equal front[COMM] planes; lit pixels appear BLANK_CYC cycles after the COMM change.
//  - Writes: when wr_valid && wr_ready, back[wr_row] <= {wr_red, wr_green, wr_blue} at that
//    edge. The front bank is never writable.
//  - Commit: frame_commit while !commit_pending sets commit_pending next cycle. wr_ready=0 while
//    pending. frame_commit while pending is ignored.
//  - Swap: on the row 7->0 advance, if commit_pending was already 1 before that edge:
//    - front/back select toggles, effective for the new row 0;
//    - commit_pending clears;
//    - wr_ready=1 from the next cycle;
//    - the new back bank holds the previous front contents and is not cleared.
//    A commit arriving on the wrap edge itself swaps one frame later.
//  - Write and commit in the same cycle: the write lands, then the bank locks.
//  - Out-of-order or repeated row writes are legal; last write wins. Unwritten rows keep old data.
// CONFIGURATION
//  LED_DIM_EN defined:
//    - adds input dim_level[2:0];
//    - after blanking, lit pixels are driven only while
//      (prescaler-BLANK_CYC) < ((dim_level+1)*(ROW_DIV-BLANK_CYC))>>3, else 8'hFF;
//    - dim_level=7 is full brightness;
//    - dim_level is sampled at frame_start and held for the frame.
//  LED_DIM_EN undefined: no dim_level port; full row time lit; no dimming logic.
// STRUCTURE
//  Package led_matrix_pkg:
//    - ROWS=8, COLS=8, PIX_OFF=8'hFF;
//    - typedef logic[7:0] row_t;
//    - typedef struct {row_t r, g, b;} rgb_row_t.
//  One sub-module, scan_tick_gen: ROW_DIV prescaler, row counter, frame_start, blank flag.
//  Two rgb_row_t[8] register banks plus a 1-bit front select live in the top level.
// TESTING
//  1 Reset: hold clear 3 cycles -> EN=0, rgb=FF, wr_ready=0; next cycle EN=1, wr_ready=1, COMM=0.
//  2 Scan timing (ROW_DIV=40, BLANK_CYC=4): COMM steps 0..7 every 40 cycles; frame_start period 320;
//    rgb=FF for 4 cycles after each COMM change.
//  3 Write rows 0..7 with green=~(1<<row), then commit mid-row 3:
//    - pending=1 and wr_ready=0 until row 7->0;
//    - green on row k = ~(1<<k) from the new frame.
//  4 Frame A visible, write B row 2 with wr_valid held through commit:
//    - accepted row 2 data appears only after swap;
//    - writes while pending are not accepted; second commit while pending is ignored.
//  5 Commit asserted on the exact wrap edge -> no swap that frame; swap at the following 7->0.
//  6 clear pulsed mid-row 5 with pending=1 -> pending=0, COMM=0, all outputs FF, banks blank.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the LED matrix scan driver.
// Optional feature macro: LED_DIM_EN (adds per-frame brightness control).
package led_matrix_pkg;

  localparam int unsigned ROWS  = 8;
  localparam int unsigned COLS  = 8;
  localparam int unsigned ROW_W = $clog2(ROWS);

  typedef logic [COLS-1:0] row_t;

  // Active-low drive: all ones means every pixel dark.
  localparam row_t PIX_OFF = 8'hFF;

  typedef struct packed {
    row_t r;
    row_t g;
    row_t b;
  } rgb_row_t;

  localparam rgb_row_t RGB_OFF = '{r: PIX_OFF, g: PIX_OFF, b: PIX_OFF};

endpackage

// File: rtl/scan_tick_gen.sv
// Row timing for the LED matrix: prescaler, row counter, frame_start pulse and the
// next-cycle blanking flag used by the registered colour outputs.
// Optional feature macro: LED_DIM_EN (shortens the lit window per dim_level).
module scan_tick_gen
  import led_matrix_pkg::*;
#(
  parameter int unsigned ROW_DIV   = 10002,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic             CLK,
  input  logic             clear,
`ifdef LED_DIM_EN
  input  logic [2:0]       dim_level,
`endif
  output logic [ROW_W-1:0] row,
  output logic             frame_start,
  output logic             frame_wrap,
  output logic             blank_nxt
);

  localparam int unsigned PW = $clog2(ROW_DIV);

  logic [PW-1:0]    presc_q, presc_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             row_tick;
  logic             fs_q;

  // Next prescaler/row values; frame_wrap marks the row 7 -> 0 edge.
  always_comb begin
    row_tick   = (presc_q == PW'(ROW_DIV - 1));
    presc_d    = row_tick ? '0 : presc_q + 1'b1;
    row_d      = row_tick ? row_q + 1'b1 : row_q;
    frame_wrap = row_tick && (row_q == ROW_W'(ROWS - 1));
  end

`ifdef LED_DIM_EN
  logic [2:0]  dim_q;
  int unsigned lit_off;
  int unsigned lit_len;

  // Blank during the anti-ghost window and after the dimmed lit window closes.
  always_comb begin
    lit_off   = 32'(presc_d) - BLANK_CYC;
    lit_len   = ((32'(dim_q) + 1) * (ROW_DIV - BLANK_CYC)) >> 3;
    blank_nxt = (32'(presc_d) < BLANK_CYC) || (lit_off >= lit_len);
  end

  // Brightness is latched as the new frame starts and held for the whole frame.
  always_ff @(posedge CLK) begin
    if (clear) begin
      dim_q <= 3'd7;
    end else if (frame_wrap) begin
      dim_q <= dim_level;
    end
  end
`else
  // Blank only during the anti-ghost window at the start of each row.
  always_comb begin
    blank_nxt = (32'(presc_d) < BLANK_CYC);
  end
`endif

  // Prescaler, row counter and frame_start register.
  always_ff @(posedge CLK) begin
    if (clear) begin
      presc_q <= '0;
      row_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      row_q   <= row_d;
      fs_q    <= frame_wrap;
    end
  end

  assign row         = row_q;
  assign frame_start = fs_q;

endmodule

// File: rtl/led_matrix_scan_driver.sv
// Double-buffered 8x8 RGB matrix scanner. Game logic writes rows into the back bank and
// requests a commit; the banks swap only at the row 7 -> 0 boundary so frames never tear.
// Optional feature macro: LED_DIM_EN (adds dim_level input for per-frame brightness).
module led_matrix_scan_driver
  import led_matrix_pkg::*;
#(
  parameter int unsigned ROW_DIV   = 10002,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic       CLK,
  input  logic       clear,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_red,
  input  logic [7:0] wr_green,
  input  logic [7:0] wr_blue,
  input  logic       frame_commit,
  output logic       commit_pending,
  output logic       frame_start,
`ifdef LED_DIM_EN
  input  logic [2:0] dim_level,
`endif
  output logic [2:0] COMM,
  output logic       EN,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue
);

  rgb_row_t         bank_q [2][ROWS];
  logic             front_q, front_d;
  logic             pending_q, pending_d;
  logic             wr_ready_q;
  logic             en_q;
  rgb_row_t         pix_q;
  logic             wr_fire;
  logic [ROW_W-1:0] row;
  logic             fs;
  logic             frame_wrap;
  logic             blank_nxt;

  scan_tick_gen #(
    .ROW_DIV  (ROW_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) u_tick (
    .CLK        (CLK),
    .clear      (clear),
`ifdef LED_DIM_EN
    .dim_level  (dim_level),
`endif
    .row        (row),
    .frame_start(fs),
    .frame_wrap (frame_wrap),
    .blank_nxt  (blank_nxt)
  );

  // Commit/swap decision. A commit seen on the wrap edge itself only arms pending, so the
  // swap happens one frame later; commits while pending are ignored.
  always_comb begin
    wr_fire   = wr_valid && wr_ready_q;
    front_d   = front_q;
    pending_d = pending_q;
    if (frame_wrap && pending_q) begin
      front_d   = ~front_q;
      pending_d = 1'b0;
    end else if (frame_commit && !pending_q) begin
      pending_d = 1'b1;
    end
  end

  // Control state: front select, pending flag, write-ready and matrix enable.
  always_ff @(posedge CLK) begin
    if (clear) begin
      front_q    <= 1'b0;
      pending_q  <= 1'b0;
      wr_ready_q <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      front_q    <= front_d;
      pending_q  <= pending_d;
      wr_ready_q <= ~pending_d;
      en_q       <= 1'b1;
    end
  end

  // Frame banks; only the back bank is ever written, and only while unlocked.
  always_ff @(posedge CLK) begin
    if (clear) begin
      for (int bk = 0; bk < 2; bk++) begin
        for (int rw = 0; rw < ROWS; rw++) begin
          bank_q[bk][rw] <= RGB_OFF;
        end
      end
    end else if (wr_fire) begin
      bank_q[~front_q][wr_row] <= '{r: wr_red, g: wr_green, b: wr_blue};
    end
  end

  // Registered column drive; blank_nxt is aligned to the prescaler value after this edge.
  always_ff @(posedge CLK) begin
    if (clear || blank_nxt) begin
      pix_q <= RGB_OFF;
    end else begin
      pix_q <= bank_q[front_q][row];
    end
  end

  assign wr_ready       = wr_ready_q;
  assign commit_pending = pending_q;
  assign frame_start    = fs;
  assign COMM           = row;
  assign EN             = en_q;
  assign red            = pix_q.r;
  assign green          = pix_q.g;
  assign blue           = pix_q.b;

endmodule
